// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes (common to the transmitter and
// receiver) and 8N1 frame constants.
package uart_pkg;

    // State codes 0..10; codes 11..15 are never entered.
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        BIT_0 = 4'd2,
        BIT_1 = 4'd3,
        BIT_2 = 4'd4,
        BIT_3 = 4'd5,
        BIT_4 = 4'd6,
        BIT_5 = 4'd7,
        BIT_6 = 4'd8,
        BIT_7 = 4'd9,
        STOP  = 4'd10
    } uart_state_e;

    localparam uart_state_e STATE_LAST = STOP;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/sync2.sv
// Single-bit two-flop synchronizer with a configurable reset value.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/wbs_uart_rx.sv
// Wishbone read-only UART receiver (8N1). Holds the most recent byte in a
// single-entry register; a newer byte overwrites an unread one.
// Optional macro UART_RX_FRAME_CHECK_EN: discard frames whose stop bit is 0.
module wbs_uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned TICKS_PER_BAUD = 0
) (
    input  logic       wbs_clk_i,
    input  logic       wbs_rst_i,
    input  logic       wbs_stb_i,
    output logic       wbs_ack_o,
    output logic [7:0] wbs_dat_o,
    input  logic       uart_rx,
    output logic       uart_rx_ready
);

    localparam int unsigned CNT_W = (TICKS_PER_BAUD > 1) ? $clog2(TICKS_PER_BAUD) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICKS_PER_BAUD / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TICKS_PER_BAUD - 1);

    logic                 w_rx_s;
    uart_state_e          r_state;
    uart_state_e          w_state_next;
    logic [CNT_W-1:0]     r_baud_cnt;
    logic [CNT_W-1:0]     w_baud_cnt_next;
    logic                 w_shift_en;
    logic                 w_stop_done;
    logic                 w_load;
    logic                 w_read;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_rx_valid;
    logic                 r_ack;
    logic [7:0]           r_dat;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync2 (
        .i_clk (wbs_clk_i),
        .i_rst (wbs_rst_i),
        .i_d   (uart_rx),
        .o_q   (w_rx_s)
    );

    // Next-state decode: start qualification at mid start bit, then one
    // sample per bit period at mid bit.
    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_stop_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (r_baud_cnt == CNT_HALF) begin
                    w_state_next = w_rx_s ? IDLE : BIT_0;
                end
            end
            BIT_0, BIT_1, BIT_2, BIT_3, BIT_4, BIT_5, BIT_6, BIT_7: begin
                if (r_baud_cnt == CNT_FULL) begin
                    w_shift_en   = 1'b1;
                    w_state_next = uart_state_e'(r_state + 4'd1);
                end
            end
            STOP: begin
                if (r_baud_cnt == CNT_FULL) begin
                    w_stop_done  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Counter restarts on every state change and idles at zero.
    always_comb begin
        w_baud_cnt_next = r_baud_cnt + CNT_W'(1);
        if ((w_state_next != r_state) || (r_state == IDLE)) begin
            w_baud_cnt_next = '0;
        end
    end

`ifdef UART_RX_FRAME_CHECK_EN
    assign w_load = w_stop_done && w_rx_s;
`else
    assign w_load = w_stop_done;
`endif

    assign w_read = wbs_stb_i && !r_ack;

    // FSM state register.
    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bit-period counter and LSB-first shift register.
    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            r_baud_cnt <= '0;
            r_shift    <= '0;
        end else begin
            r_baud_cnt <= w_baud_cnt_next;
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    // Holding register; a load in the same cycle as a read-clear wins.
    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            r_hold     <= '0;
            r_rx_valid <= 1'b0;
        end else if (w_load) begin
            r_hold     <= r_shift;
            r_rx_valid <= 1'b1;
        end else if (w_read) begin
            r_rx_valid <= 1'b0;
        end
    end

    // Bus response: one-cycle ack, data zero outside the ack cycle.
    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 8'h00;
        end else begin
            r_ack <= w_read;
            r_dat <= (w_read && r_rx_valid) ? r_hold : 8'h00;
        end
    end

    assign wbs_ack_o     = r_ack;
    assign wbs_dat_o     = r_dat;
    assign uart_rx_ready = r_rx_valid;

endmodule

// File: tb/tb_wbs_uart_rx.sv
// Self-checking bench for wbs_uart_rx with TICKS_PER_BAUD=4. Expectations come
// from a simple byte/valid model updated per frame and per bus read.
module tb_wbs_uart_rx;
    import uart_pkg::*;

    localparam int unsigned T = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       stb;
    logic       ack;
    logic [7:0] dat;
    logic       rx;
    logic       ready;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    bit         exp_valid = 1'b0;
    logic [7:0] exp_byte  = 8'h00;
`ifdef UART_RX_FRAME_CHECK_EN
    bit         frame_check_en = 1'b1;
`else
    bit         frame_check_en = 1'b0;
`endif

    always #5 clk = ~clk;

    wbs_uart_rx #(
        .TICKS_PER_BAUD (T)
    ) dut (
        .wbs_clk_i     (clk),
        .wbs_rst_i     (rst),
        .wbs_stb_i     (stb),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (dat),
        .uart_rx       (rx),
        .uart_rx_ready (ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one full 8N1 frame, T cycles per bit, then return the line high.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10 * T; i++) begin
            rx = bits[i/T];
            tick();
        end
        rx = 1'b1;
    endtask

    function automatic void model_load(input logic [7:0] d, input logic stop_bit);
        if (stop_bit || !frame_check_en) begin
            exp_valid = 1'b1;
            exp_byte  = d;
        end
    endfunction

    task automatic frame_done(input logic [7:0] d, input logic stop_bit);
        tick();
        model_load(d, stop_bit);
    endtask

    task automatic bus_read(input string tag);
        stb = 1'b1;
        tick();
        check({tag, "_ack"}, ack, 1);
        check({tag, "_dat"}, dat, exp_valid ? exp_byte : 8'h00);
        stb = 1'b0;
        exp_valid = 1'b0;
        check({tag, "_ready"}, ready, exp_valid);
        tick();
        check({tag, "_ack_drop"}, ack, 0);
        check({tag, "_dat_zero"}, dat, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic       sb;

        rst = 1'b1;
        stb = 1'b0;
        rx  = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_ack", ack, 0);
        check("reset_dat", dat, 0);
        check("reset_ready", ready, 0);

        // 0x55: ready must appear on the 41st cycle after the line falls.
        send_frame(8'h55, 1'b1);
        check("ready_cycle40", ready, 0);
        frame_done(8'h55, 1'b1);
        check("ready_cycle41", ready, 1);
        bus_read("rd_55");

        // Read with nothing held.
        bus_read("rd_empty");

        // Strobe held two cycles: exactly one ack.
        stb = 1'b1;
        tick();
        check("stb2_first", ack, 1);
        tick();
        check("stb2_second", ack, 0);
        stb = 1'b0;
        tick();
        check("stb2_after", ack, 0);

        // Strobe held continuously: ack every other cycle.
        stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stb_cont", ack, (i % 2 == 0) ? 1 : 0);
        end
        stb = 1'b0;
        tick();

        // One-cycle glitch must not produce a byte.
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (3 * T) tick();
        check("glitch_ready", ready, 0);

        // Back-to-back frames with no read: newest wins.
        send_frame(8'hA5, 1'b1);
        model_load(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        frame_done(8'h3C, 1'b1);
        check("b2b_ready", ready, 1);
        bus_read("rd_overrun");

        // Bad stop bit on 0xFF.
        send_frame(8'hFF, 1'b0);
        frame_done(8'hFF, 1'b0);
        repeat (2 * T) tick();
        check("badstop_ready", ready, frame_check_en ? 0 : 1);
        bus_read("rd_badstop");

        // Read coincident with the STOP load.
        send_frame(8'h34, 1'b1);
        frame_done(8'h34, 1'b1);
        send_frame(8'h12, 1'b1);
        stb = 1'b1;
        tick();
        check("coinc_ack", ack, 1);
        check("coinc_dat", dat, 8'h34);
        check("coinc_ready", ready, 1);
        stb = 1'b0;
        exp_valid = 1'b1;
        exp_byte  = 8'h12;
        tick();
        bus_read("rd_coinc_new");

        // Reset pulsed during BIT_3 with a byte already held.
        send_frame(8'h5A, 1'b1);
        frame_done(8'h5A, 1'b1);
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'h81, 1'b0};
            for (int i = 0; i < 18; i++) begin
                rx = bits[i/T];
                tick();
            end
        end
        check("pre_rst_state", 32'(dut.r_state), 32'(BIT_3));
        rst = 1'b1;
        rx  = 1'b1;
        tick();
        rst = 1'b0;
        exp_valid = 1'b0;
        exp_byte  = 8'h00;
        check("midrst_ack", ack, 0);
        check("midrst_dat", dat, 0);
        check("midrst_ready", ready, 0);
        check("midrst_state", 32'(dut.r_state), 32'(IDLE));
        repeat (2 * T) tick();
        check("midrst_settled", ready, 0);
        send_frame(8'h81, 1'b1);
        frame_done(8'h81, 1'b1);
        check("post_rst_ready", ready, 1);
        bus_read("rd_81");

        // Randomized frames and reads.
        for (int it = 0; it < 25; it++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            send_frame(d, sb);
            frame_done(d, sb);
            check("rnd_ready", ready, exp_valid);
            repeat (2 * T) tick();
            if ($urandom_range(0, 1) == 1) begin
                bus_read("rnd_rd");
            end
        end
        bus_read("rnd_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
